hamming_mem_engine: RTL

- Hardware SECDED Hamming engine that walks a block of data memory and writes results to a second region.
- Encode mode: converts 11-bit messages into 16-bit (15,11)+overall-parity codewords, the program 1 function.
- Decode mode: checks and corrects codewords back into flagged messages, the program 2 function.
- Sits beside top_level's data memory as a bus master; generalised in message count, base addresses and mode.

---
 rtl/hamming_mem_engine_if.sv | 42 ++++
 rtl/hamming_mem_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_mem_engine_if.sv
//------------------------------------------------------------------------------
// Module   : hamming_mem_engine_if
// Purpose  : Groups the control handshake and the byte-wide memory bus of the
//            Hamming memory engine.
// Ports    : master modport (engine side):
//              in  : start, mode, mem_rdata
//              out : busy, done, mem_addr, mem_wr_en, mem_wdata,
//                    single_cnt, double_cnt
//            slave modport (system / memory side) has the mirrored directions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hamming_mem_engine_if #(
   parameter int ADDR_W  = 8,
   parameter int NUM_MSG = 15
);
   localparam int CNT_W = $clog2(NUM_MSG + 1);

   logic              start;
   logic              mode;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr_en;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic [CNT_W-1:0]  single_cnt;
   logic [CNT_W-1:0]  double_cnt;

   modport master (
      input  start, mode, mem_rdata,
      output busy, done, mem_addr, mem_wr_en, mem_wdata, single_cnt, double_cnt
   );

   modport slave (
      output start, mode, mem_rdata,
      input  busy, done, mem_addr, mem_wr_en, mem_wdata, single_cnt, double_cnt
   );
endinterface

`default_nettype wire

// File: rtl/hamming_mem_engine.sv
//------------------------------------------------------------------------------
// Module   : hamming_mem_engine
// Purpose  : SECDED Hamming engine acting as a memory bus master. Walks
//            NUM_MSG little-endian byte pairs starting at SRC_BASE and writes
//            one result pair per item starting at DST_BASE.
//            mode 0: 11-bit message -> 16-bit (15,11)+p0 codeword.
//            mode 1: codeword -> corrected message with 2-bit error flag.
// Ports    : clk   - rising-edge clock
//            reset - synchronous, active-low reset
//            bus   - hamming_mem_engine_if.master (start/mode/busy/done,
//                    mem_addr/mem_wr_en/mem_wdata/mem_rdata, error counters)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hamming_mem_engine #(
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 30,
   parameter int ADDR_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   hamming_mem_engine_if.master bus
);

   localparam int                CNT_W  = $clog2(NUM_MSG + 1);
   localparam logic [ADDR_W-1:0] c_SRC  = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] c_DST  = ADDR_W'(DST_BASE);
   localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(NUM_MSG - 1);
   localparam logic [CNT_W-1:0]  c_MAX  = CNT_W'(NUM_MSG);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3,
      S_WR0  = 3'd4,
      S_WR1  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] single_q, single_d;
   logic [CNT_W-1:0] double_q, double_d;
   logic [7:0]       lo_q, lo_d;
   logic [7:0]       hi_q, hi_d;
   logic             mode_q, mode_d;

   // Datapath: result bytes derived combinationally from the captured pair
   logic [10:0]       w_din;
   logic [15:0]       w_enc;
   logic [15:0]       w_rx;
   logic [15:0]       w_fix;
   logic [3:0]        w_syn;
   logic              w_par;
   logic [10:0]       w_dout;
   logic [1:0]        w_flag;
   logic [7:0]        w_res_lo;
   logic [7:0]        w_res_hi;
   logic [ADDR_W-1:0] w_src_a;
   logic [ADDR_W-1:0] w_dst_a;

   always_comb begin
      // Encode: data bits occupy the non-power-of-two positions 3,5,6,7,9..15
      w_din     = {hi_q[2:0], lo_q};
      w_enc     = '0;
      w_enc[3]  = w_din[0];
      w_enc[7:5] = w_din[3:1];
      w_enc[15:9] = w_din[10:4];
      // Each mask selects positions whose index has the given bit set; the
      // parity slots are still zero here so they do not disturb the XOR.
      w_enc[1]  = ^(w_enc & 16'hAAAA);
      w_enc[2]  = ^(w_enc & 16'hCCCC);
      w_enc[4]  = ^(w_enc & 16'hF0F0);
      w_enc[8]  = ^(w_enc & 16'hFF00);
      w_enc[0]  = ^w_enc[15:1];

      // Decode: syndrome equals XOR of the indices of all set bits 1..15
      w_rx      = {hi_q, lo_q};
      w_syn[0]  = ^(w_rx & 16'hAAAA);
      w_syn[1]  = ^(w_rx & 16'hCCCC);
      w_syn[2]  = ^(w_rx & 16'hF0F0);
      w_syn[3]  = ^(w_rx & 16'hFF00);
      w_par     = ^w_rx;
      w_fix     = w_rx;
      if (w_par && (w_syn != 4'd0)) begin
         w_fix[w_syn] = ~w_rx[w_syn];
      end
      w_dout    = {w_fix[15:9], w_fix[7:5], w_fix[3]};
      if (w_par) begin
         w_flag = 2'b01;
      end else if (w_syn != 4'd0) begin
         w_flag = 2'b10;
      end else begin
         w_flag = 2'b00;
      end

      if (mode_q) begin
         w_res_lo = w_dout[7:0];
         w_res_hi = {w_flag, 3'b000, w_dout[10:8]};
      end else begin
         w_res_lo = w_enc[7:0];
         w_res_hi = w_enc[15:8];
      end

      w_src_a = c_SRC + ADDR_W'({idx_q, 1'b0});
      w_dst_a = c_DST + ADDR_W'({idx_q, 1'b0});
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         single_q <= '0;
         double_q <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         single_q <= single_d;
         double_q <= double_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         mode_q   <= mode_d;
      end
   end

   // Next-state and bus outputs
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      single_d       = single_q;
      double_d       = double_q;
      lo_d           = lo_q;
      hi_d           = hi_q;
      mode_d         = mode_q;
      bus.mem_addr   = '0;
      bus.mem_wr_en  = 1'b0;
      bus.mem_wdata  = 8'h00;
      bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
      bus.done       = (state_q == S_DONE);
      bus.single_cnt = single_q;
      bus.double_cnt = double_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d  = S_RD0;
               idx_d    = '0;
               single_d = '0;
               double_d = '0;
               mode_d   = bus.mode;
            end
         end
         S_RD0: begin
            bus.mem_addr = w_src_a;
            state_d      = S_RD1;
         end
         S_RD1: begin
            bus.mem_addr = w_src_a + 1'b1;
            lo_d         = bus.mem_rdata;
            state_d      = S_RD2;
         end
         S_RD2: begin
            hi_d    = bus.mem_rdata;
            state_d = S_WR0;
         end
         S_WR0: begin
            // Strobe is masked by reset so an abort in this cycle writes nothing
            bus.mem_addr  = w_dst_a;
            bus.mem_wr_en = reset;
            bus.mem_wdata = w_res_lo;
            state_d       = S_WR1;
         end
         S_WR1: begin
            bus.mem_addr  = w_dst_a + 1'b1;
            bus.mem_wr_en = reset;
            bus.mem_wdata = w_res_hi;
            if (mode_q) begin
               if (w_flag[0] && (single_q != c_MAX)) single_d = single_q + 1'b1;
               if (w_flag[1] && (double_q != c_MAX)) double_d = double_q + 1'b1;
            end
            if (idx_q == c_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_RD0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire
